keyboard_frame_controller: RTL and testbench

Receive-side sequencer for the PS/2 keyboard port. It conditions the raw keyboard clock and data lines using the debounce and synchronizer settings from `keyboard_bus_interface`. It then deframes 11-bit PS/2 frames, checks start, parity and stop bits, and assembles E0/F0-prefixed scan-code sequences into the 24-bit `key_code`. Its outputs feed the status fields of the keyboard device register at 0x30000000.

---
 rtl/keyboard_frame_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_keyboard_frame_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_frame_controller.sv
// keyboard_frame_controller
// Receive-side sequencer for the PS/2 keyboard port. The raw keyboard clock and
// data lines are synchronised and the clock line is debounced. Each 11-bit frame
// is deframed and its start, parity and stop bits are checked. E0/F0 prefix
// bytes are gathered into a 24-bit scan-code sequence.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data     raw keyboard lines, asynchronous to clk
//   debounce_time         filter length for ps2_clk, in clk cycles
//   synchronizer_enable   1: two-stage input synchroniser, 0: one stage
//   key_code              last complete scan-code sequence, right-aligned
//   key_valid             one-cycle pulse whenever key_code is updated
//   frame_error           last frame had a bad stop bit or timed out
//   parity_error          last frame failed the odd-parity check
module keyboard_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [4:0]  debounce_time,
  input  logic        synchronizer_enable,
  output logic [23:0] key_code,
  output logic        key_valid,
  output logic        frame_error,
  output logic        parity_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // True when data byte plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic        clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic        sync_clk, sync_data;
  logic        filt_clk_q, filt_clk_d;
  logic [4:0]  db_cnt_q, db_cnt_d;
  logic        fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] pending_q, pending_d;
  logic [1:0]  pend_cnt_q, pend_cnt_d;
  logic [23:0] key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        parity_error_q, parity_error_d;
  logic        par_bad, stop_bad;

  // Input synchroniser chain; both stages always run so the tap can switch freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign sync_clk  = synchronizer_enable ? clk_sync_q  : clk_meta_q;
  assign sync_data = synchronizer_enable ? data_sync_q : data_meta_q;

  // Debounce filter: accept a new clock level after debounce_time+1 differing cycles.
  always_comb begin
    filt_clk_d = filt_clk_q;
    db_cnt_d   = 5'd0;
    if (sync_clk != filt_clk_q) begin
      if (db_cnt_q == debounce_time) begin
        filt_clk_d = sync_clk;
        db_cnt_d   = 5'd0;
      end else begin
        db_cnt_d   = db_cnt_q + 5'd1;
      end
    end else begin
      db_cnt_d = 5'd0;
    end
  end

  // The falling edge is the cycle in which the filter commits a 1->0 change;
  // sync_data is sampled in that same cycle.
  assign fall = filt_clk_q & ~filt_clk_d;

  // Frame FSM, timeout and scan-code assembler next-state logic.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    tmo_d          = tmo_q;
    pending_d      = pending_q;
    pend_cnt_d     = pend_cnt_q;
    key_code_d     = key_code_q;
    key_valid_d    = 1'b0;
    frame_error_d  = frame_error_q;
    parity_error_d = parity_error_q;
    par_bad        = ~odd_parity_ok(shift_q, parity_q);
    stop_bad       = ~sync_data;

    case (state_q)
      IDLE: begin
        if (fall && !sync_data) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {sync_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = sync_data;
          state_d  = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (fall) begin
          state_d        = IDLE;
          parity_error_d = par_bad;
          frame_error_d  = stop_bad;
          if (par_bad || stop_bad) begin
            pending_d  = 16'h0000;
            pend_cnt_d = 2'd0;
          end else if ((shift_q == 8'hE0 || shift_q == 8'hF0) && pend_cnt_q < 2'd2) begin
            pending_d  = {pending_q[7:0], shift_q};
            pend_cnt_d = pend_cnt_q + 2'd1;
          end else begin
            key_valid_d = 1'b1;
            case (pend_cnt_q)
              2'd0:    key_code_d = {16'h0000, shift_q};
              2'd1:    key_code_d = {8'h00, pending_q[7:0], shift_q};
              default: key_code_d = {pending_q, shift_q};
            endcase
            pending_d  = 16'h0000;
            pend_cnt_d = 2'd0;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Inter-edge timeout; state actions above happen only on a falling edge,
    // so the timeout branch never competes with them.
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d          = '0;
      state_d        = IDLE;
      frame_error_d  = 1'b1;
      parity_error_d = 1'b0;
      pending_d      = 16'h0000;
      pend_cnt_d     = 2'd0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q     <= 1'b1;
      db_cnt_q       <= 5'd0;
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      pending_q      <= 16'h0000;
      pend_cnt_q     <= 2'd0;
      key_code_q     <= 24'h000000;
      key_valid_q    <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      filt_clk_q     <= filt_clk_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      tmo_q          <= tmo_d;
      pending_q      <= pending_d;
      pend_cnt_q     <= pend_cnt_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
    end
  end

  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;

endmodule

// File: tb/tb_keyboard_frame_controller.sv
// Testbench for keyboard_frame_controller: directed PS/2 frames with a
// scoreboard of expected published codes, popped by a key_valid monitor.
module tb_keyboard_frame_controller;

  localparam int TMO = 100;
  localparam int H   = 20;   // PS/2 half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [4:0]  debounce_time = 5'd2;
  logic        synchronizer_enable = 1'b1;
  logic [23:0] key_code;
  logic        key_valid;
  logic        frame_error;
  logic        parity_error;

  keyboard_frame_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ps2_clk             (ps2_clk),
    .ps2_data            (ps2_data),
    .debounce_time       (debounce_time),
    .synchronizer_enable (synchronizer_enable),
    .key_code            (key_code),
    .key_valid           (key_valid),
    .frame_error         (frame_error),
    .parity_error        (parity_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] code;
    logic        ferr;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [23:0] code);
    exp_t e;
    e.code = code;
    e.ferr = 1'b0;
    e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: every key_valid cycle pops one expected publish and compares.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && key_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_key_valid: actual code 0x%06h required no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {8'h00, key_code}, {8'h00, e.code});
        check("frame_error_at_valid", {31'd0, frame_error}, {31'd0, e.ferr});
        check("parity_error_at_valid", {31'd0, parity_error}, {31'd0, e.perr});
      end
    end
  end

  // One PS/2 bit: data set while clock high, optional 3-cycle low glitch, then a low phase.
  task automatic ps2_bit(input logic b, input int glitch_at);
    @(negedge clk);
    ps2_data = b;
    if (glitch_at >= 0) begin
      repeat (glitch_at) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H - glitch_at - 3) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // glitch_mode: 0 none, 1 glitch before every bit, 2 glitch before data bit 0 only.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                            input int glitch_mode);
    logic [10:0] bits;
    bits = {stop_bit, (~(^b)) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i], (glitch_mode == 1 || (glitch_mode == 2 && i == 1)) ? 5 : -1);
    end
    repeat (H) @(negedge clk);
  endtask

  // Start bit plus n data bits, then the clock line stays high.
  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0, -1);
    for (int i = 0; i < n; i++) begin
      ps2_bit(b[i], -1);
    end
  endtask

  initial begin
    int v;
    int c;

    repeat (3) @(negedge clk);
    check("reset_key_code", {8'h00, key_code}, 32'h0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single good byte.
    push(24'h00001C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);

    // Prefixed sequence E0 F0 74.
    v = n_valid;
    push(24'hE0F074);
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    check("no_valid_after_prefixes", n_valid, v);
    send_frame(8'h74, 1'b0, 1'b1, 0);
    check("one_valid_after_sequence", n_valid, v + 1);

    // Parity error, then a good frame clears it.
    v = n_valid;
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check("perr_parity_error", {31'd0, parity_error}, 32'd1);
    check("perr_frame_error", {31'd0, frame_error}, 32'd0);
    check("perr_key_code_hold", {8'h00, key_code}, 32'h00E0F074);
    check("perr_no_valid", n_valid, v);
    push(24'h00001C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);

    // Bad stop bit.
    v = n_valid;
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("stop_frame_error", {31'd0, frame_error}, 32'd1);
    check("stop_parity_error", {31'd0, parity_error}, 32'd0);
    check("stop_key_code_hold", {8'h00, key_code}, 32'h0000001C);
    check("stop_no_valid", n_valid, v);

    // Timeout mid-frame; the pending E0 must be discarded.
    push(24'h000032);
    send_frame(8'h32, 1'b0, 1'b1, 0);
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_partial(8'h29, 4);
    c = H;
    while (!frame_error && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("timeout_latency_in_range", {31'd0, (c >= 100 && c <= 110)}, 32'd1);
    check("timeout_parity_error", {31'd0, parity_error}, 32'd0);
    check("timeout_key_code_hold", {8'h00, key_code}, 32'h00000032);
    push(24'h000029);
    send_frame(8'h29, 1'b0, 1'b1, 0);

    // Single-stage synchroniser.
    synchronizer_enable = 1'b0;
    push(24'h000016);
    send_frame(8'h16, 1'b0, 1'b1, 0);
    synchronizer_enable = 1'b1;

    // Short glitches are filtered with debounce_time=5.
    debounce_time = 5'd5;
    push(24'h00005A);
    send_frame(8'h5A, 1'b0, 1'b1, 1);

    // With debounce_time=0 one glitch is an extra edge: the stop slot sees the parity bit (0).
    debounce_time = 5'd0;
    v = n_valid;
    send_frame(8'h1C, 1'b0, 1'b1, 2);
    check("glitch_frame_error", {31'd0, frame_error}, 32'd1);
    check("glitch_parity_error", {31'd0, parity_error}, 32'd0);
    check("glitch_key_code_hold", {8'h00, key_code}, 32'h0000005A);
    check("glitch_no_valid", n_valid, v);
    debounce_time = 5'd2;

    // Reset mid-frame after a pending F0.
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_partial(8'h70, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_key_code", {8'h00, key_code}, 32'h0);
    check("midreset_key_valid", {31'd0, key_valid}, 32'd0);
    check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    check("midreset_parity_error", {31'd0, parity_error}, 32'd0);
    repeat (5) @(negedge clk);
    push(24'h00E070);
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h70, 1'b0, 1'b1, 0);

    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("valid_pulse_count", n_valid, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
